// File: rtl/vga_text_writer.sv
// Write-side engine for the 40x30 text-mode VRAM: takes character codes over
// valid/ready, writes {color, code} at the cursor, handles CR/LF/BS/FF and scrolls.
module vga_text_writer #(
    parameter int          COLS  = 40,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_in,
    input  logic [2:0]  color_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [12:0] vram_addr,
    output logic [10:0] vram_din,
    output logic        vram_wen,
    input  logic [10:0] vram_dout,
    output logic [12:0] Cursor,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        SCROLL_RD,
        SCROLL_WR,
        CLEAR_ROW,
        CLEAR_ALL
    } state_t;

    localparam logic [7:0]  CH_BS = 8'h08;
    localparam logic [7:0]  CH_LF = 8'h0A;
    localparam logic [7:0]  CH_FF = 8'h0C;
    localparam logic [7:0]  CH_CR = 8'h0D;

    localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
    localparam logic [5:0]  ROW_LAST    = 6'(ROWS - 1);
    localparam logic [12:0] COLS13      = 13'(COLS);
    localparam logic [12:0] SCROLL_LAST = 13'((ROWS - 1) * COLS - 1);
    localparam logic [12:0] CLEAR_LAST  = 13'(ROWS * COLS - 1);
    localparam logic [10:0] BLANK_WORD  = {3'b000, BLANK};

    state_t      state;
    logic [5:0]  row_q;
    logic [6:0]  col_q;
    logic [7:0]  code_q;
    logic [12:0] s_q;
    logic [12:0] addr_q;
    logic [10:0] din_q;
    logic        wen_q;

    logic [12:0] cur_addr;
    logic        at_origin;
    logic        need_scroll;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    assign cur_addr    = ({7'd0, row_q} * COLS13) + {6'd0, col_q};
    assign at_origin   = (row_q == 6'd0) && (col_q == 7'd0);
    assign need_scroll = (row_q == ROW_LAST) &&
                         ((is_printable(code_q) && (col_q == COL_LAST)) || (code_q == CH_LF));

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values; later assignments in the block override earlier ones.
        if (rst) begin
            state  <= IDLE;
            row_q  <= '0;
            col_q  <= '0;
            code_q <= '0;
            s_q    <= '0;
            addr_q <= '0;
            din_q  <= '0;
            wen_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wen_q <= 1'b0;
                    if (char_valid) begin
                        code_q <= char_in;
                        state  <= EXEC;
                        // The write is staged at accept so it is on the port during EXEC.
                        if (is_printable(char_in)) begin
                            addr_q <= cur_addr;
                            din_q  <= {color_in, char_in};
                            wen_q  <= 1'b1;
                        end else if ((char_in == CH_BS) && !at_origin) begin
                            addr_q <= cur_addr - 13'd1;
                            din_q  <= BLANK_WORD;
                            wen_q  <= 1'b1;
                        end
                    end
                end

                EXEC: begin
                    wen_q <= 1'b0;
                    state <= IDLE;
                    if (is_printable(code_q)) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q != ROW_LAST) row_q <= row_q + 6'd1;
                        end else begin
                            col_q <= col_q + 7'd1;
                        end
                    end else begin
                        case (code_q)
                            CH_CR: col_q <= '0;
                            CH_LF: begin
                                col_q <= '0;
                                if (row_q != ROW_LAST) row_q <= row_q + 6'd1;
                            end
                            CH_BS: begin
                                if (col_q != 7'd0) begin
                                    col_q <= col_q - 7'd1;
                                end else if (row_q != 6'd0) begin
                                    row_q <= row_q - 6'd1;
                                    col_q <= COL_LAST;
                                end
                            end
                            CH_FF: begin
                                row_q  <= '0;
                                col_q  <= '0;
                                state  <= CLEAR_ALL;
                                s_q    <= '0;
                                addr_q <= '0;
                                din_q  <= BLANK_WORD;
                                wen_q  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    if (need_scroll) begin
                        state  <= SCROLL_RD;
                        s_q    <= '0;
                        addr_q <= COLS13;
                    end
                end

                SCROLL_RD: begin
                    state  <= SCROLL_WR;
                    addr_q <= s_q;
                    wen_q  <= 1'b1;
                end

                SCROLL_WR: begin
                    s_q <= s_q + 13'd1;
                    if (s_q == SCROLL_LAST) begin
                        state  <= CLEAR_ROW;
                        addr_q <= s_q + 13'd1;
                        din_q  <= BLANK_WORD;
                        wen_q  <= 1'b1;
                    end else begin
                        state  <= SCROLL_RD;
                        addr_q <= s_q + 13'd1 + COLS13;
                        wen_q  <= 1'b0;
                    end
                end

                CLEAR_ROW, CLEAR_ALL: begin
                    if (s_q == CLEAR_LAST) begin
                        state <= IDLE;
                        wen_q <= 1'b0;
                    end else begin
                        s_q    <= s_q + 13'd1;
                        addr_q <= s_q + 13'd1;
                        wen_q  <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Scroll copies pass read data straight through; it arrives during SCROLL_WR.
    assign vram_din   = (state == SCROLL_WR) ? vram_dout : din_q;
    assign vram_addr  = addr_q;
    assign vram_wen   = wen_q;
    assign Cursor     = {row_q, col_q};
    assign char_ready = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: table-driven single-character vectors
// plus hand-written line-wrap, clear-screen, scroll and reset-abort sequences.
module tb_vga_text_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_in;
    logic [2:0]  color_in;
    logic        char_valid;
    logic        char_ready;
    logic [12:0] vram_addr;
    logic [10:0] vram_din;
    logic        vram_wen;
    logic [10:0] vram_dout;
    logic [12:0] Cursor;
    logic        busy;

    logic        preload;
    logic [10:0] mem [0:8191];
    logic [12:0] wa [$];
    logic [10:0] wd [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .color_in   (color_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .vram_addr  (vram_addr),
        .vram_din   (vram_din),
        .vram_wen   (vram_wen),
        .vram_dout  (vram_dout),
        .Cursor     (Cursor),
        .busy       (busy)
    );

    function automatic logic [10:0] pattern(input int r);
        return {3'(r % 8), 8'(8'h41 + r)};
    endfunction

    // Synchronous-read VRAM model with a one-cycle bulk preload of row patterns.
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 1200; a++) mem[a] <= pattern(a / 40);
        end else if (vram_wen) begin
            mem[vram_addr] <= vram_din;
        end
        vram_dout <= mem[vram_addr];
    end

    always @(posedge clk) begin
        if (vram_wen) begin
            wa.push_back(vram_addr);
            wd.push_back(vram_din);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        char_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_char(input logic [7:0] c, input logic [2:0] col);
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) check("ready_timeout", 32'd0, 32'd1);
        char_in    = c;
        color_in   = col;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(output int low);
        low = 0;
        @(negedge clk);
        while (!char_ready && low < 5000) begin
            low++;
            @(negedge clk);
        end
        if (!char_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] c, input logic [2:0] col, output int low);
        drive_char(c, col);
        wait_idle(low);
    endtask

    typedef struct {
        logic [7:0]  c;
        logic [2:0]  color;
        int          n_wr;
        logic [12:0] addr;
        logic [10:0] din;
        logic [12:0] cursor;
    } vec_t;

    initial begin
        vec_t vecs [12];
        int   low;
        int   base;
        int   bad;
        int   n;

        vecs[0]  = '{8'h41, 3'd2, 1, 13'd0,  11'h241, 13'h0001};
        vecs[1]  = '{8'h0D, 3'd0, 0, 13'd0,  11'h000, 13'h0000};
        vecs[2]  = '{8'h07, 3'd0, 0, 13'd0,  11'h000, 13'h0000};
        vecs[3]  = '{8'h08, 3'd0, 0, 13'd0,  11'h000, 13'h0000};
        vecs[4]  = '{8'h0A, 3'd0, 0, 13'd0,  11'h000, 13'h0080};
        vecs[5]  = '{8'h08, 3'd0, 1, 13'd39, 11'h020, 13'h0027};
        vecs[6]  = '{8'h7E, 3'd7, 1, 13'd39, 11'h77E, 13'h0080};
        vecs[7]  = '{8'h7F, 3'd5, 0, 13'd0,  11'h000, 13'h0080};
        vecs[8]  = '{8'h20, 3'd1, 1, 13'd40, 11'h120, 13'h0081};
        vecs[9]  = '{8'h08, 3'd3, 1, 13'd40, 11'h020, 13'h0080};
        vecs[10] = '{8'h1F, 3'd4, 0, 13'd0,  11'h000, 13'h0080};
        vecs[11] = '{8'h0D, 3'd0, 0, 13'd0,  11'h000, 13'h0080};

        rst        = 1'b1;
        char_valid = 1'b0;
        char_in    = '0;
        color_in   = '0;
        preload    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  32'(char_ready), 32'd0);
        check("rst_cursor", 32'(Cursor),     32'd0);
        check("rst_wen",    32'(vram_wen),   32'd0);
        check("rst_addr",   32'(vram_addr),  32'd0);
        check("rst_din",    32'(vram_din),   32'd0);
        rst = 1'b0;
        #1;
        check("release_ready", 32'(char_ready), 32'd1);
        check("release_busy",  32'(busy),       32'd0);

        for (int i = 0; i < 12; i++) begin
            base = wa.size();
            send(vecs[i].c, vecs[i].color, low);
            n = wa.size() - base;
            check($sformatf("vec%0d_nwr", i), 32'(n), 32'(vecs[i].n_wr));
            if (vecs[i].n_wr > 0 && n > 0) begin
                check($sformatf("vec%0d_addr", i), 32'(wa[base]), 32'(vecs[i].addr));
                check($sformatf("vec%0d_din", i),  32'(wd[base]), 32'(vecs[i].din));
            end
            check($sformatf("vec%0d_cursor", i), 32'(Cursor), 32'(vecs[i].cursor));
            check($sformatf("vec%0d_low", i),    32'(low),    32'd1);
        end

        // A full row of printable characters wraps to the next row.
        do_reset();
        base = wa.size();
        for (int i = 0; i < 40; i++) send(8'(8'h41 + i), 3'(i), low);
        n = wa.size() - base;
        check("row_nwr", 32'(n), 32'd40);
        bad = 0;
        for (int i = 0; i < 40 && i < n; i++) begin
            if (wa[base + i] !== 13'(i) || wd[base + i] !== {3'(i), 8'(8'h41 + i)}) bad++;
        end
        check("row_data_bad", 32'(bad), 32'd0);
        if (n > 0) check("row_last_addr", 32'(wa[wa.size() - 1]), 32'd39);
        check("row_cursor", 32'(Cursor), 32'h0080);

        // Clear screen, then an ignored code leaves the cursor where it was.
        base = wa.size();
        send(8'h0C, 3'd6, low);
        n = wa.size() - base;
        check("ff_low",    32'(low),    32'd1201);
        check("ff_nwr",    32'(n),      32'd1200);
        check("ff_cursor", 32'(Cursor), 32'd0);
        bad = 0;
        for (int i = 0; i < 1200 && i < n; i++) begin
            if (wa[base + i] !== 13'(i) || wd[base + i] !== 11'h020) bad++;
        end
        check("ff_order_bad", 32'(bad), 32'd0);
        send(8'h41, 3'd1, low);
        base = wa.size();
        send(8'h07, 3'd1, low);
        check("bel_nwr",    32'(wa.size() - base), 32'd0);
        check("bel_cursor", 32'(Cursor),           32'h0001);

        // Scroll from (29,5) on LF with every row preloaded with its own pattern.
        do_reset();
        for (int i = 0; i < 29; i++) send(8'h0A, 3'd0, low);
        for (int i = 0; i < 5; i++) send(8'h5A, 3'd0, low);
        check("pre_scroll_cursor", 32'(Cursor), 32'h0E85);
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        base = wa.size();
        send(8'h0A, 3'd0, low);
        check("scroll_low",    32'(low),              32'd2361);
        check("scroll_nwr",    32'(wa.size() - base), 32'd1200);
        check("scroll_cursor", 32'(Cursor),           32'h0E80);
        for (int r = 0; r < 29; r++) begin
            bad = 0;
            for (int c = 0; c < 40; c++) if (mem[r * 40 + c] !== pattern(r + 1)) bad++;
            check($sformatf("scroll_row%0d_bad", r), 32'(bad), 32'd0);
        end
        bad = 0;
        for (int a = 1160; a < 1200; a++) if (mem[a] !== 11'h020) bad++;
        check("scroll_clear_row_bad", 32'(bad), 32'd0);

        // Reset in the middle of a scroll aborts at once.
        do_reset();
        for (int i = 0; i < 29; i++) send(8'h0A, 3'd0, low);
        base = wa.size();
        drive_char(8'h0A, 3'd0);
        n = 0;
        while ((wa.size() - base) < 500 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("abort_progress", 32'(wa.size() - base), 32'd500);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_wen",    32'(vram_wen),   32'd0);
        check("abort_cursor", 32'(Cursor),     32'd0);
        check("abort_ready",  32'(char_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_release_ready", 32'(char_ready), 32'd1);
        base = wa.size();
        send(8'h41, 3'd2, low);
        n = wa.size() - base;
        check("abort_next_nwr", 32'(n), 32'd1);
        if (n > 0) begin
            check("abort_next_addr", 32'(wa[base]), 32'd0);
            check("abort_next_din",  32'(wd[base]), 32'h241);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
